// File: rtl/vector_demux.sv
// vector_demux: routes one 4-lane x 32-bit vector per cycle into one of two
// single-entry holding banks, selected by control. Each bank drains through
// its own valid/ready pair and keeps an 8-bit count of delivered vectors.
// Lane contents are opaque (IEEE-754 singles passed through untouched).
module vector_demux (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] vin1,
  input  logic [31:0] vin2,
  input  logic [31:0] vin3,
  input  logic [31:0] vin4,
  input  logic        in_valid,
  input  logic        control,
  output logic        in_ready,
  output logic [31:0] vout11,
  output logic [31:0] vout12,
  output logic [31:0] vout13,
  output logic [31:0] vout14,
  output logic [31:0] vout21,
  output logic [31:0] vout22,
  output logic [31:0] vout23,
  output logic [31:0] vout24,
  output logic        valid1,
  output logic        valid2,
  input  logic        ready1,
  input  logic        ready2,
  output logic [7:0]  cnt1,
  output logic [7:0]  cnt2
);

  logic accept;
  logic load1;
  logic load2;
  logic deliver1;
  logic deliver2;

  // Source handshake: the selected bank can take a vector if it is empty or
  // is being drained this same cycle, which gives one vector per cycle.
  always_comb begin
    in_ready = 1'b0;
    if (control) begin
      in_ready = !valid2 || ready2;
    end else begin
      in_ready = !valid1 || ready1;
    end
    accept   = in_valid && in_ready;
    load1    = accept && !control;
    load2    = accept && control;
    deliver1 = valid1 && ready1;
    deliver2 = valid2 && ready2;
  end

  // Bank 1 holding register: load wins over drain, data kept after drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout11 <= 32'd0;
      vout12 <= 32'd0;
      vout13 <= 32'd0;
      vout14 <= 32'd0;
      valid1 <= 1'b0;
    end else if (load1) begin
      vout11 <= vin1;
      vout12 <= vin2;
      vout13 <= vin3;
      vout14 <= vin4;
      valid1 <= 1'b1;
    end else if (deliver1) begin
      valid1 <= 1'b0;
    end
  end

  // Bank 2 holding register: same behaviour as bank 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout21 <= 32'd0;
      vout22 <= 32'd0;
      vout23 <= 32'd0;
      vout24 <= 32'd0;
      valid2 <= 1'b0;
    end else if (load2) begin
      vout21 <= vin1;
      vout22 <= vin2;
      vout23 <= vin3;
      vout24 <= vin4;
      valid2 <= 1'b1;
    end else if (deliver2) begin
      valid2 <= 1'b0;
    end
  end

  // Delivered-vector counters; free-running 8-bit wrap is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else begin
      if (deliver1) cnt1 <= cnt1 + 8'd1;
      if (deliver2) cnt2 <= cnt2 + 8'd1;
    end
  end

endmodule

// File: doc/vector_demux.md
VECTOR_DEMUX -- requirements
Module: vector_demux

Interface
REQ-001: The module SHALL have no parameters; lane count is fixed at 4 and lane width at 32 bits, with each lane carrying an IEEE-754 single-precision value that is passed through unmodified.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: vin1, vin2, vin3, vin4  input  32 each  source vector lanes 1..4.
REQ-005: in_valid  input  1  source vector present.
REQ-006: control  input  1  destination select: 0 selects bank 1, 1 selects bank 2.
REQ-007: in_ready  output  1  source vector accepted this cycle when high together with in_valid.
REQ-008: vout11, vout12, vout13, vout14  output  32 each  bank-1 held lanes 1..4.
REQ-009: vout21, vout22, vout23, vout24  output  32 each  bank-2 held lanes 1..4.
REQ-010: valid1, valid2  output  1 each  bank holds an undelivered vector.
REQ-011: ready1, ready2  input  1 each  bank consumer takes the vector this cycle.
REQ-012: cnt1, cnt2  output  8 each  delivered-vector count per bank.

Function
REQ-013: Each bank SHALL be a one-entry holding register consisting of 4x32 data bits plus a valid flag.
REQ-014: The selected bank d SHALL be bank 1 when control=0 and bank 2 when control=1.
REQ-015: in_ready SHALL be combinational and equal (!valid_d || ready_d) for the selected bank d.
REQ-016: Accept is defined as in_valid && in_ready; on accept, the selected bank SHALL load vin1..vin4 into lanes 1..4 in lane order and SHALL set its valid flag at the next clk edge, giving a latency of 1 cycle.
REQ-017: Deliver is defined, for bank k, as valid_k && ready_k; on deliver without a simultaneous load into bank k, valid_k SHALL clear at the next edge and the bank data SHALL be retained.
REQ-018: On deliver and load into the same bank in the same cycle, valid_k SHALL remain 1 and the data SHALL be replaced by the new vector, giving full throughput of one vector per cycle.
REQ-019: While valid_k=1 and ready_k=0, bank k data and valid_k SHALL be held stable.
REQ-020: The non-selected bank SHALL be unaffected by an accept and SHALL still drain independently via its own ready.
REQ-021: Both banks MAY deliver in the same cycle.
REQ-022: Changes on control or vin* while in_valid=0 SHALL cause no state change.
REQ-023: If in_valid=1 and in_ready=0, no state change SHALL occur for the source, and the source SHALL hold its vector; re-evaluation uses the current control value.
REQ-024: cnt_k SHALL increment by 1 on each deliver of bank k and SHALL wrap from 255 to 0.
REQ-025: ready_k asserted while valid_k=0 SHALL have no effect and SHALL NOT increment cnt_k.

Reset
REQ-026: While rst=1, all bank data SHALL be 0, valid1=valid2=0, and cnt1=cnt2=0, taking effect immediately and independently of clk.
REQ-027: Reset asserted mid-operation SHALL discard held vectors without delivering them, and no counter SHALL increment.
REQ-028: During reset, in_ready SHALL follow REQ-015 using the cleared valid flags, i.e. it reads 1, but no load SHALL occur while rst=1.
REQ-029: The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-030: Route to bank 1. Stimulus: reset, then control=0, in_valid=1, vin1..vin4=0x41BA6666, 0x3F99999A, 0x40666666, 0x40B9999A, ready1=0. Response: after 1 edge, valid1=1, vout11..vout14 equal those values, valid2=0, and in_ready=0 on the next cycle.
REQ-031: Route to bank 2 while bank 1 is blocked. Stimulus: bank 1 held full, then control=1, vin=0x40DCCCCD, 0x4259999A, 0x42C7CCCD, 0x416CCCCD. Response: in_ready=1, bank 2 loads these values, and bank 1 is unchanged.
REQ-032: Back-to-back streaming. Stimulus: control=0, ready1=1, 10 consecutive vectors. Response: in_ready stays 1, each vector appears on vout1x one cycle after its accept, and cnt1=10.
REQ-033: Backpressure. Stimulus: ready1=0 for 5 cycles with in_valid=1. Response: vout1x stable, cnt1 unchanged, and no accept occurs; releasing ready1 delivers the held vector and then accepts the next.
REQ-034: Counter wrap. Stimulus: 256 deliveries to bank 2. Response: cnt2 goes 255 -> 0.
REQ-035: Asynchronous reset. Stimulus: assert rst between edges while valid1=valid2=1. Response: valids, data and counters clear immediately, and no deliver is counted.
